// File: rtl/fir_tdm_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR filter.
package fir_tdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int tap_w(input int num_taps);
    return $clog2(num_taps);
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + tap_w(num_taps);
  endfunction

endpackage

// File: rtl/fir_tdm_mac.sv
// Multiply-accumulate datapath with round-half-up and output reduction.
// FIR_SAT_EN selects saturation; otherwise the result wraps to DATA_W bits.
module fir_tdm_mac
  import fir_tdm_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int COEF_W   = 12,
  parameter int NUM_TAPS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] sample,
  output logic        [DATA_W-1:0] result
);

  localparam int ACC_W  = acc_w(DATA_W, COEF_W, NUM_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  // Half an LSB of the Q1.(COEF_W-1) scale, added before the shift.
  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W - COEF_W + 2){1'b0}}, 1'b1, {(COEF_W - 2){1'b0}}};

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    acc_ext;
  logic signed [ACC_W:0]    biased;
  logic signed [ACC_W:0]    shifted;

  assign product = coef * sample;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
    end
  end

  assign acc_ext = {acc[ACC_W-1], acc};
  assign biased  = acc_ext + HALF;
  assign shifted = biased >>> (COEF_W - 1);

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W:0] MAX_V =
    {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V =
    {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  always_comb begin
    result = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      result = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      result = MIN_V[DATA_W-1:0];
    end
  end
`else
  logic unused_high_bits;
  assign unused_high_bits = ^shifted[ACC_W:DATA_W];
  assign result           = shifted[DATA_W-1:0];
`endif

endmodule

// File: rtl/fir_tdm_filter.sv
// Multi-channel TDM FIR: per-channel history lines, shadow/active coefficient
// banks and the IDLE->MAC->OUT sequencer. Build with FIR_SAT_EN for saturation.
module fir_tdm_filter
  import fir_tdm_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int COEF_W   = 12,
  parameter int NUM_TAPS = 16,
  parameter int NUM_CH   = 4,
  localparam int CH_W    = ch_w(NUM_CH),
  localparam int TAP_W   = tap_w(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  input  logic              cfg_we,
  input  logic [TAP_W-1:0]  cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata,
  input  logic              cfg_commit,
  input  logic [TAP_W-1:0]  cfg_raddr,
  output logic [COEF_W-1:0] cfg_rdata,
  output logic              commit_pending,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a source holds valid and its payload unchanged until then.

  fir_state_e state, state_next;

  logic [TAP_W-1:0]  tap_cnt;
  logic [CH_W-1:0]   cur_ch;
  logic [DATA_W-1:0] hist   [NUM_CH][NUM_TAPS];
  logic [COEF_W-1:0] shadow [NUM_TAPS];
  logic [COEF_W-1:0] active [NUM_TAPS];
  logic [DATA_W-1:0] mac_result;
  logic              ch_ok;
  logic              push;
  logic              copy_now;
  logic              mac_en;

  if (NUM_CH == (1 << CH_W)) begin : g_all_ch
    assign ch_ok = 1'b1;
  end else begin : g_some_ch
    assign ch_ok = (int'(in_ch) < NUM_CH);
  end

  // Out-of-range channels complete the handshake but are dropped here.
  assign push     = (state == ST_IDLE) && in_valid && ch_ok;
  assign copy_now = (state == ST_IDLE) && commit_pending;
  assign mac_en   = (state == ST_MAC);
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (push) state_next = ST_MAC;
      ST_MAC:  if (tap_cnt == TAP_W'(NUM_TAPS - 1)) state_next = ST_OUT;
      ST_OUT:  if (out_valid && out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tap_cnt   <= '0;
      cur_ch    <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      state <= state_next;
      if (push) begin
        tap_cnt <= '0;
        cur_ch  <= in_ch;
      end else if (state == ST_MAC) begin
        tap_cnt <= tap_cnt + TAP_W'(1);
      end
      // The first OUT cycle lets the last product land in the accumulator.
      if (state == ST_OUT) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_ch    <= cur_ch;
          out_data  <= mac_result;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          hist[c][k] <= '0;
        end
      end
    end else if (push) begin
      for (int k = NUM_TAPS - 1; k > 0; k--) begin
        hist[in_ch][k] <= hist[in_ch][k-1];
      end
      hist[in_ch][0] <= in_data;
    end
  end

  // A commit only takes effect from IDLE, so an in-flight result never sees
  // a bank change; a sample accepted on the copy edge uses the new bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      commit_pending <= 1'b0;
      cfg_rdata      <= '0;
    end else begin
      if (cfg_we) begin
        shadow[cfg_addr] <= cfg_wdata;
      end
      if (copy_now) begin
        active <= shadow;
      end
      if (cfg_commit) begin
        commit_pending <= 1'b1;
      end else if (copy_now) begin
        commit_pending <= 1'b0;
      end
      cfg_rdata <= active[cfg_raddr];
    end
  end

  fir_tdm_mac #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .NUM_TAPS (NUM_TAPS)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (push),
    .en     (mac_en),
    .coef   (active[tap_cnt]),
    .sample (hist[cur_ch][tap_cnt]),
    .result (mac_result)
  );

endmodule

// File: doc/fir_tdm_filter.md
FIR_TDM_FILTER -- requirements
Module: fir_tdm_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 12, signed sample width for input and output.
REQ-002 SHALL have parameter COEF_W, default 12, signed Q1.(COEF_W-1) coefficient width.
REQ-003 SHALL have parameter NUM_TAPS, default 16, taps per channel, power of two, 2 or more.
REQ-004 SHALL have parameter NUM_CH, default 4, channel count, power of two, 1 or more.
REQ-005 SHALL have ports (CH_W = max(1,clog2(NUM_CH)), TAP_W = clog2(NUM_TAPS)):
- Clk  in  1  sole clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid / in_ready  in/out  1  sample handshake.
- in_ch  in  CH_W  channel of the offered sample.
- in_data  in  DATA_W  signed sample.
- out_valid / out_ready  out/in  1  result handshake.
- out_ch  out  CH_W  channel of the result.
- out_data  out  DATA_W  signed filtered sample.
- cfg_we  in  1  shadow coefficient write strobe.
- cfg_addr  in  TAP_W  tap index for write.
- cfg_wdata  in  COEF_W  coefficient value.
- cfg_commit  in  1  request swap of shadow bank into active bank.
- cfg_raddr  in  TAP_W  active-bank read index.
- cfg_rdata  out  COEF_W  active coefficient, registered.
- commit_pending  out  1  commit requested, not yet applied.
- busy  out  1  FSM not in IDLE.

Function
REQ-006 SHALL run FSM IDLE -> MAC -> OUT -> IDLE; in_ready = 1 only in IDLE; busy = (state != IDLE).
REQ-007 SHALL, on IDLE with in_valid, push in_data into history line in_ch (newest = x[n], oldest dropped) and enter MAC next edge.
REQ-008 SHALL spend exactly NUM_TAPS cycles in MAC, one multiply-accumulate per cycle, tap k = active coef[k] * x[n-k], k = 0..NUM_TAPS-1.
REQ-009 SHALL use a full-precision accumulator of ACC_W = DATA_W+COEF_W+TAP_W bits, cleared at MAC entry.
REQ-010 SHALL produce out_data = (acc + 2^(COEF_W-2)) >>> (COEF_W-1), arithmetic shift, round half up, then reduced to DATA_W per REQ-019.
REQ-011 SHALL assert out_valid with out_ch and out_data exactly NUM_TAPS+1 cycles after the accept edge, holding them stable until out_ready; return to IDLE on the edge where out_valid & out_ready.
REQ-012 SHALL keep channel histories independent; a sample on one channel never affects another channel's output.
REQ-013 SHALL accept but discard samples with in_ch >= NUM_CH: history untouched, no output, FSM stays IDLE.
REQ-014 SHALL write cfg_wdata to shadow[cfg_addr] on cfg_we in any state; the active bank is not affected.
REQ-015 SHALL set commit_pending on cfg_commit; copy shadow to active on the first edge with state IDLE and commit_pending, then clear commit_pending; a sample accepted on that same edge uses the new bank.
REQ-016 SHALL, when cfg_we and cfg_commit coincide, include that write in the committed bank.
REQ-017 SHALL present cfg_rdata = active[cfg_raddr] one cycle after cfg_raddr is applied.

Reset
REQ-018 SHALL, on Reset, set state IDLE, zero all histories, both banks, the accumulator, and cfg_rdata; set out_valid, out_ch, out_data, and commit_pending to 0; discard any in-flight computation.

Configuration
REQ-019 SHALL, with FIR_SAT_EN defined, saturate the rounded result to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; without it, keep only the low DATA_W bits (two's-complement wrap).

Structure
REQ-020 SHALL place the FSM state enum and the CH_W/TAP_W/ACC_W width helper functions in shared package fir_tdm_pkg.
REQ-021 SHALL implement multiply, accumulate, round, and saturate/wrap in sub-module fir_tdm_mac; fir_tdm_filter holds the FSM, histories, and banks.

Verification
REQ-022 SHALL check: shadow coef[k] = 100*(k+1), commit, ch0 impulse 1024 followed by 15 zeros -> out_data 50, 100, ..., 800; first result 17 cycles after the accept edge.
REQ-023 SHALL check: coef[0] = 1024, 1000 on ch1 interleaved with 0s on ch0 -> ch1 = 500, ch0 = 0 throughout.
REQ-024 SHALL check: all coefs = 2047, 16 samples of 2047 on ch0 -> last out_data = 2047 with FIR_SAT_EN, -32 without.
REQ-025 SHALL check: cfg_commit during MAC -> commit_pending = 1 until OUT completes; in-flight result uses the old bank, next sample uses the new bank.
REQ-026 SHALL check: out_ready held low 5 cycles -> out_valid/out_data stable, in_ready = 0; Reset asserted mid-MAC -> out_valid = 0, next impulse response starts from zeroed history.
